ifu_fetch: RTL
==============

Name: ifu_fetch

Overview:
- Multi-cycle instruction fetch unit for the NPC core; owns the architectural PC.
- Issues one read to instruction memory over a valid/ready request channel and captures the response.
- Presents the instruction to the decode stage over a valid/ready handshake, then waits for the next PC from execute before fetching again.
- Replaces the combinational PC register + instruction memory read path of the single-cycle datapath.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction data.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_resp_valid  in  1  read data valid (single cycle pulse)
- imem_resp_data  in  XLEN  instruction word
- imem_resp_err  in  1  bus/access error for this response
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  XLEN  instruction word
- inst_pc  out  XLEN  PC of inst
- inst_fault  out  1  fetch fault flag accompanying inst
- npc_valid  in  1  execute presents next PC
- npc  in  XLEN  next PC (branch/jump target or pc+4)
- npc_ready  out  1  IFU accepts npc (high only in S_NEXT)
- pc  out  XLEN  current PC (exported for difftest)

Behaviour:
- Clock clk; reset rst is synchronous, active-high, sampled on rising edge; all state updates on rising edge.
- Reset values: pc=RESET_PC, state=S_REQ, inst=0, inst_pc=RESET_PC, inst_fault=0; hence imem_req_valid=1 in the first cycle after rst deasserts; inst_valid=0, npc_ready=0.
- FSM (2-bit state):
  - S_REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready -> S_WAIT. Request held stable (valid and addr unchanged) until accepted.
  - S_WAIT: wait for imem_resp_valid; on it, register inst<=imem_resp_data, inst_pc<=pc, inst_fault<=imem_resp_err -> S_OUT. A response in the same cycle as request acceptance is not allowed (memory contract); minimum latency request-accept to inst_valid = 2 cycles.
  - S_OUT: inst_valid=1, inst/inst_pc/inst_fault stable; on inst_ready -> S_NEXT.
  - S_NEXT: npc_ready=1; on npc_valid, pc<=npc -> S_REQ.
- Exactly one outstanding request; imem_resp_valid outside S_WAIT is ignored (dropped, no state change).
- npc_valid outside S_NEXT is ignored; execute must hold npc_valid/npc until npc_ready.
- Faulted instruction (imem_resp_err=1): inst still presented with inst_fault=1; inst forced to 32'h00000013 (nop) so decode produces no side effects; the fault is reported downstream via inst_fault.
- rst asserted in any state (including S_WAIT mid-transaction) returns to reset values next edge; memory shares rst and discards in-flight reads.
- npc is taken verbatim (no increment inside IFU); pc wraps modulo 2^32 as supplied.
- Throughput: one instruction per (req wait + resp latency + 2) cycles minimum; no prefetch.

Optional Feature:
- Macro IFU_ALIGN_CHECK_EN.
- Defined: in S_REQ, if pc[1:0]!=0 no memory request is issued (imem_req_valid=0); next cycle state=S_OUT with inst=32'h00000013, inst_fault=1, inst_pc=pc.
- Undefined: no check; the address is issued unmodified and alignment is the memory's concern.

Decomposition:
- Shared package (npc_pkg): XLEN, RESET_PC default, NOP_INST=32'h00000013, ifu state enum {S_REQ,S_WAIT,S_OUT,S_NEXT}.
- No sub-module needed; the pc register may reuse the existing generic Reg with reset value RESET_PC. The FSM and instruction buffer live in ifu_fetch.

Test Plan:
- Reset release, imem_req_ready=1, resp 1 cycle later data=32'h00100093 -> req addr 0x80000000 in cycle 1; inst_valid in cycle 3 with inst=0x00100093, inst_pc=0x80000000, inst_fault=0.
- Backpressure: imem_req_ready low 3 cycles then high -> imem_req_valid held with stable addr all 4 cycles; one request only. inst_ready low 5 cycles -> inst held stable, npc_ready=0.
- Redirect: after inst handshake, npc=0x80000100 with npc_valid -> next request addr 0x80000100; a stray npc_valid asserted during S_WAIT leaves pc unchanged.
- Error response: imem_resp_err=1, data=0xFFFFFFFF -> inst=0x00000013, inst_fault=1.
- Reset mid-flight: rst in S_WAIT, then a late imem_resp_valid -> response ignored; new request to 0x80000000 after rst deasserts.
- With IFU_ALIGN_CHECK_EN: npc=0x80000002 -> no imem_req_valid; inst_fault=1, inst_pc=0x80000002. Without the macro -> request issued to 0x80000002.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared NPC core definitions: datapath width, reset PC, canonical nop,
// IFU state encoding and a small alignment helper.
package npc_pkg;

    localparam int          NPC_XLEN     = 32;
    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;   // addi x0, x0, 0

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_NEXT = 2'd3
    } ifu_state_e;

    // True when the low address bits select a 32-bit word boundary.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch unit. Owns the architectural PC, issues one
// instruction memory read at a time, buffers the response for decode and
// then waits for execute to supply the next PC.
// Optional build macro IFU_ALIGN_CHECK_EN: a misaligned PC raises a fetch
// fault (nop + inst_fault) without touching memory.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int              XLEN     = NPC_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = NPC_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    output logic            npc_ready,
    output logic [XLEN-1:0] pc
);

`ifdef IFU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INST);

    ifu_state_e state;
    logic       req_valid_q;
    logic       inst_valid_q;
    logic       npc_ready_q;

    // With the check disabled every address is sent to memory as-is.
    function automatic logic addr_ok(input logic [XLEN-1:0] a);
        return !ALIGN_CHECK || is_word_aligned(a[1:0]);
    endfunction

    // Handshake flags are registered and updated together with the state,
    // so each one is high exactly while its state is current.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            inst         <= '0;
            inst_pc      <= RESET_PC;
            inst_fault   <= 1'b0;
            req_valid_q  <= addr_ok(RESET_PC);
            inst_valid_q <= 1'b0;
            npc_ready_q  <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (!addr_ok(pc)) begin
                        // Misaligned fetch never reaches memory; report it as a faulted nop.
                        inst         <= NOP;
                        inst_pc      <= pc;
                        inst_fault   <= 1'b1;
                        inst_valid_q <= 1'b1;
                        state        <= S_OUT;
                    end else if (imem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        // A faulted word is replaced by a nop so decode has no side effects.
                        inst         <= imem_resp_err ? NOP : imem_resp_data;
                        inst_pc      <= pc;
                        inst_fault   <= imem_resp_err;
                        inst_valid_q <= 1'b1;
                        state        <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        npc_ready_q  <= 1'b1;
                        state        <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (npc_valid) begin
                        pc          <= npc;
                        npc_ready_q <= 1'b0;
                        req_valid_q <= addr_ok(npc);
                        state       <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc;
    assign inst_valid     = inst_valid_q;
    assign npc_ready      = npc_ready_q;

endmodule
